// File: rtl/master_bus_port_if.sv
// master_bus_port_if: serial bus link between one master port and the controller/slave side
//   master modport: drives m_req, bus_util, bus_dout, bus_dout_valid;
//                   samples m_grant, bus_din, bus_din_valid, slave_ack, slave_split
//   slave modport : the mirror image, used by the controller/slave side
interface master_bus_port_if;
  logic m_req;
  logic m_grant;
  logic bus_util;
  logic bus_dout;
  logic bus_dout_valid;
  logic bus_din;
  logic bus_din_valid;
  logic slave_ack;
  logic slave_split;
  modport master (
    output m_req, bus_util, bus_dout, bus_dout_valid,
    input  m_grant, bus_din, bus_din_valid, slave_ack, slave_split
  );
  modport slave (
    input  m_req, bus_util, bus_dout, bus_dout_valid,
    output m_grant, bus_din, bus_din_valid, slave_ack, slave_split
  );
endinterface

// File: rtl/master_bus_port.sv
// master_bus_port: sequences one core read/write over the shared serial bus (request, grant, shift, ack, split, timeout)
//   clk, rstn           : clock, asynchronous active-low reset
//   start_i/wr_i/addr_i/wdata_i : core request, latched in IDLE
//   rdata_o/busy_o/done_o/err_o : core result and status
//   bus                 : serial bus link (master modport)
module master_bus_port #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  master_bus_port_if.master bus
);
  localparam int SW = ADDR_W + 1 + DATA_W;
  localparam int BW = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, SPLIT, RELEASE} state_t;
  state_t st_q, st_d;
  // {wr, addr, wdata} shifted out MSB first: ADDR drains the top ADDR_W+1 bits, WDATA the rest
  logic [SW-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic wr_q, wr_d, err_q, err_d, tmo_hit;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st_q  <= IDLE;
      sh_q  <= '0;
      rd_q  <= '0;
      bc_q  <= '0;
      tmo_q <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      sh_q  <= sh_d;
      rd_q  <= rd_d;
      bc_q  <= bc_d;
      tmo_q <= tmo_d;
      wr_q  <= wr_d;
      err_q <= err_d;
    end
  assign tmo_inc = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
  // this idle cycle is the TIMEOUT-th one, so leave at its end
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    rd_d  = rd_q;
    bc_d  = bc_q;
    tmo_d = tmo_q;
    wr_d  = wr_q;
    err_d = err_q;
    case (st_q)
      IDLE: if (start_i) begin
        st_d  = REQ;
        wr_d  = wr_i;
        sh_d  = {wr_i, addr_i, wdata_i};
        rd_d  = '0;
        err_d = 1'b0;
      end
      REQ: st_d = bus.m_grant ? ADDR : REQ;
      ADDR: begin
        sh_d = sh_q << 1;
        bc_d = bc_q + 1'b1;
        st_d = (bc_q == BW'(ADDR_W)) ? WAIT_ACK : ADDR;
      end
      WAIT_ACK: begin
        tmo_d = tmo_inc;
        if (bus.slave_split && !wr_q) st_d = SPLIT;
        else if (bus.slave_ack) st_d = wr_q ? WDATA : RDATA;
        else if (tmo_hit) begin
          st_d  = RELEASE;
          err_d = 1'b1;
        end
      end
      WDATA: begin
        sh_d = sh_q << 1;
        bc_d = bc_q + 1'b1;
        st_d = (bc_q == BW'(DATA_W - 1)) ? RELEASE : WDATA;
      end
      RDATA: if (bus.bus_din_valid) begin
        rd_d  = {rd_q[DATA_W-2:0], bus.bus_din};
        bc_d  = bc_q + 1'b1;
        tmo_d = '0;
        st_d  = (bc_q == BW'(DATA_W - 1)) ? RELEASE : RDATA;
      end else begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          st_d  = RELEASE;
          err_d = 1'b1;
        end
      end
      SPLIT: st_d = bus.m_grant ? RDATA : SPLIT;
      RELEASE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (st_d != st_q) begin
      bc_d  = '0;
      tmo_d = '0;
    end
  end
  assign rdata_o            = rd_q;
  assign busy_o             = st_q != IDLE;
  assign done_o             = st_q == RELEASE;
  assign err_o              = done_o && err_q;
  assign bus.m_req          = st_q == REQ || st_q == SPLIT;
  assign bus.bus_util       = st_q == ADDR || st_q == WAIT_ACK || st_q == WDATA || st_q == RDATA;
  assign bus.bus_dout_valid = st_q == ADDR || st_q == WDATA;
  assign bus.bus_dout       = bus.bus_dout_valid && sh_q[SW-1];
endmodule

// File: doc/master_bus_port.md
Name: master_bus_port

Overview:
- Master-side bus interface sequencer; one instance per bus master, sits between a master core and the shared serial bus owned by the bus controller.
- Requests the bus, waits for grant, claims it via bus_util, then shifts out address, read/write flag and write data bit-serially.
- Handles the slave handshake, including split reads: it releases the bus while the slave works, then waits for the controller's re-grant to receive read data.
- Sequences each core-side read or write to completion or timeout.

Parameters:
- ADDR_W, 16, address bits shifted per transaction; the upper bits carry the slave id.
- DATA_W, 8, data bits per transfer.
- TIMEOUT, 255, maximum idle cycles allowed while waiting for slave_ack or the next read bit.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  core request; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; latched with start.
- addr  in  ADDR_W  target address; latched with start.
- wdata  in  DATA_W  write data; latched with start.
- rdata  out  DATA_W  read result; valid while done = 1 and held until the next start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on timeout.
- m_req  out  1  bus request to the controller.
- m_grant  in  1  grant from the controller.
- bus_util  out  1  master currently holds the bus.
- bus_dout  out  1  serial data to the slave, MSB first.
- bus_dout_valid  out  1  qualifies bus_dout.
- bus_din  in  1  serial read data from the slave.
- bus_din_valid  in  1  qualifies bus_din.
- slave_ack  in  1  slave accepted the address or write data.
- slave_split  in  1  slave will split this read.

Behaviour:
- Reset (async): state IDLE; all outputs 0, including rdata.
  - Bus_util drops immediately on rstn low.
  - Shift register and timeout counter are cleared.
- IDLE: start=1 latches wr, addr and wdata, then moves to REQ. start outside IDLE is ignored.
- REQ: m_req=1 and held until m_grant=1 is sampled. No timeout in REQ.
  - Next cycle: bus_util=1, m_req=0, state ADDR.
- ADDR: ADDR_W+1 cycles with bus_dout_valid=1.
  - First the wr bit, then addr[ADDR_W-1] down to addr[0].
  - Then WAIT_ACK.
- WAIT_ACK: bus_dout_valid=0; the timeout counter increments each cycle. Decision order:
  1. slave_split=1 on a read goes to SPLIT. It takes precedence over slave_ack.
  2. slave_split on a write is ignored.
  3. slave_ack=1 goes to WDATA on a write, or RDATA on a read.
  4. The counter reaching TIMEOUT goes to RELEASE with err.
  - The counter is cleared on every state entry.
- WDATA: DATA_W cycles shifting wdata MSB first with bus_dout_valid=1, then RELEASE. No second ack is required.
- RDATA: on each cycle with bus_din_valid=1, shift bus_din in at the LSB end, MSB arrives first.
  - The counter clears on every received bit.
  - After DATA_W bits, go to RELEASE.
  - If TIMEOUT cycles pass with no valid bit, go to RELEASE with err; rdata holds the partial shift.
- SPLIT: bus_util=0 and m_req=1. Wait with no timeout for m_grant=1 (the controller re-grant).
  - Next cycle: bus_util=1, m_req=0, state RDATA.
- RELEASE: one cycle with bus_util=0 and done=1; err=1 if entered by timeout. Then IDLE.
- Grant handling: m_grant is ignored outside REQ and SPLIT. The controller dropping grant mid-transfer does not abort a transfer.
- Simultaneous events: start in the RELEASE cycle is ignored. start on the cycle after done is accepted.
- Counter width is clog2(TIMEOUT+1) and it saturates.

Test Plan:
- Write, addr=16'hA5C3, wdata=8'h3C: grant after 3 cycles, ack after 2 cycles.
  - Expect bus_dout sequence 1, then A5C3 MSB-first (17 valid cycles), then 00111100 (8 cycles).
  - Expect one done pulse, err=0, bus_util high from the cycle after grant until RELEASE.
- Read, addr=16'h2001: ack, then 8 din bits of 8'h96 with bubbles (valid deasserted 2 cycles mid-byte).
  - Expect rdata=8'h96 and done=1.
- Split read: slave_split asserted in WAIT_ACK.
  - Expect bus_util=0 and m_req=1 next cycle.
  - Re-grant 40 cycles later, then din 8'h5A. Expect bus_util re-asserted one cycle after grant and rdata=8'h5A.
- Timeout: no slave_ack, TIMEOUT=255.
  - Expect err=1 and done=1 exactly 255 cycles after WAIT_ACK entry, then bus_util=0 and state IDLE.
- Reset mid-ADDR, rstn low at bit 5: expect all outputs 0 asynchronously.
  - After release, a new start completes normally.
- start pulsed while busy is ignored.
  - start held high across done: a second transaction begins in the cycle after done.
